// File: rtl/ppu_tx_fifo.sv
// Circular FIFO between the core's PPU send path and the PPU, using a valid/ready handshake.
// Sticky overflow records any send dropped while the FIFO was full.
module ppu_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ppu_send,
    input  logic [31:0]              interface_data,
    input  logic                     ppu_ready,
    input  logic                     ovf_clr,
    output logic                     ppu_valid,
    output logic [31:0]              ppu_data,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    always_comb begin
        ppu_valid   = (count != '0);
        full        = (count == CW'(DEPTH));
        almost_full = (count >= CW'(AF_THRESH));
        pop         = ppu_valid & ppu_ready;
        push        = ppu_send & (~full | pop);
        drop        = ppu_send & full & ~pop;
        ppu_data    = ppu_valid ? mem[rd_ptr] : '0;
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= interface_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_tx_fifo.sv
// Scoreboard bench for ppu_tx_fifo: directed pushes queue their expected words,
// an independent monitor checks each word as the PPU accepts it.
module tb_ppu_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        ppu_send;
    logic [31:0] interface_data;
    logic        ppu_ready;
    logic        ovf_clr;
    logic        ppu_valid;
    logic [31:0] ppu_data;
    logic        full;
    logic        almost_full;
    logic        overflow;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    ppu_tx_fifo #(.DEPTH(16), .AF_THRESH(14)) dut (
        .clk            (clk),
        .rst            (rst),
        .ppu_send       (ppu_send),
        .interface_data (interface_data),
        .ppu_ready      (ppu_ready),
        .ovf_clr        (ovf_clr),
        .ppu_valid      (ppu_valid),
        .ppu_data       (ppu_data),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .count          (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head word must match the scoreboard front.
    always @(negedge clk) begin
        if (!rst && ppu_valid && ppu_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", ppu_data, 32'hxxxx_xxxx);
            end else begin
                chk("pop_data", ppu_data, sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] d, input bit accepted);
        ppu_send       = 1'b1;
        interface_data = d;
        if (accepted) sb.push_back(d);
        step();
        ppu_send = 1'b0;
    endtask

    task automatic drain(input string name);
        ppu_ready = 1'b1;
        for (int k = 0; k < 40 && ppu_valid; k++) step();
        ppu_ready = 1'b0;
        sample();
        chk({name, "_count"}, 32'(count), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        rst = 1'b1; ppu_send = 1'b0; interface_data = '0; ppu_ready = 1'b0; ovf_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        sample();
        chk("rst_valid", 32'(ppu_valid), 32'd0);
        chk("rst_data", ppu_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        step();

        // 1: single push, hold, accept
        push_word(32'hDEAD_BEEF, 1'b1);
        sample();
        chk("t1_valid", 32'(ppu_valid), 32'd1);
        chk("t1_data", ppu_data, 32'hDEAD_BEEF);
        chk("t1_count", 32'(count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            sample();
            chk("t1_hold", ppu_data, 32'hDEAD_BEEF);
        end
        step();
        ppu_ready = 1'b1;
        step();
        ppu_ready = 1'b0;
        sample();
        chk("t1_valid_after", 32'(ppu_valid), 32'd0);
        chk("t1_data_after", ppu_data, 32'd0);
        step();

        // 2: fill, almost_full threshold, overflow, ordered drain
        for (int i = 0; i < 16; i++) begin
            push_word(32'(i), 1'b1);
            sample();
            chk("t2_af", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            chk("t2_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
            step();
        end
        push_word(32'h0000_0099, 1'b0);
        sample();
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        step();
        drain("t2_drain");
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        sample();
        chk("t2_ovf_clr", 32'(overflow), 32'd0);
        step();

        // 3: pointer wrap
        for (int r = 1; r <= 2; r++) begin
            for (int i = 0; i < 10; i++) push_word(32'(r * 256 + i), 1'b1);
            drain("t3_drain");
        end
        for (int i = 0; i < 16; i++) push_word(32'h300 + 32'(i), 1'b1);
        sample();
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'd16);
        step();

        // 4: push+pop while full
        ppu_ready = 1'b1;
        push_word(32'hA5A5_0000, 1'b1);
        ppu_ready = 1'b0;
        sample();
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_ovf", 32'(overflow), 32'd0);
        chk("t4_head", ppu_data, 32'h301);
        step();
        drain("t4_drain");

        // 5: drop and clear in same cycle, then clear alone
        for (int i = 0; i < 16; i++) push_word(32'h400 + 32'(i), 1'b1);
        ovf_clr = 1'b1;
        push_word(32'h0BAD_0BAD, 1'b0);
        ovf_clr = 1'b0;
        sample();
        chk("t5_set_wins", 32'(overflow), 32'd1);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        sample();
        chk("t5_clr", 32'(overflow), 32'd0);
        step();
        drain("t5_drain");

        // 6: reset mid-operation
        for (int i = 0; i < 7; i++) push_word(32'h500 + 32'(i), 1'b1);
        sample();
        chk("t6_pre_count", 32'(count), 32'd7);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        sample();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(ppu_valid), 32'd0);
        chk("t6_data", ppu_data, 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        step();
        // push into empty with ready high: only the push happens
        ppu_ready = 1'b1;
        push_word(32'hCAFE_F00D, 1'b1);
        ppu_ready = 1'b0;
        sample();
        chk("t6_count_one", 32'(count), 32'd1);
        chk("t6_first_out", ppu_data, 32'hCAFE_F00D);
        step();
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
